imem_loader: RTL and testbench

Boot-time writer for the single-cycle core's instruction memory. It accepts a program as a byte stream over a valid/ready handshake, validates a 16-bit word-count header, and packs bytes little-endian into DATA_WIDTH-bit words. Each word goes out on a one-cycle write strobe at consecutive word addresses 0..N-1, which is the same word-indexed layout the fetch path reads. The core is held off (busy_o) until done_o.

---
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that writes a program into instruction memory
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   start_i                       begin a load (honoured in IDLE, DONE, ERROR)
//   byte_valid_i, byte_data_i     incoming stream byte and its valid
//   byte_ready_o                  loader accepts a byte this cycle
//   wr_en_o, wr_addr_o, wr_data_o one-cycle write strobe, word index, assembled word
//   busy_o, done_o, error_o       load in progress / completed (sticky) / aborted (sticky)
//   word_count_o                  words written so far in the current load
module imem_loader #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PROGRAM_LENGTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [15:0]           word_count_o
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int IW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);
    localparam logic [15:0] MAX_N = 16'(PROGRAM_LENGTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, CHK, DONE, ERROR} state_t;
    logic [7:0] r_csum;
`else
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, DONE, ERROR} state_t;
`endif
    state_t                r_state;
    logic [15:0]           r_n;
    logic [IW-1:0]         r_byte_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [15:0]           r_word_count;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  w_fire;
    logic                  w_last_word;
    logic [15:0]           w_n;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_fire      = byte_valid_i && r_busy;
    assign w_n         = {byte_data_i, r_n[7:0]};
    assign w_last_word = (r_word_count + 16'd1) == r_n;
    // Little-endian packing: byte k lands in bits [8k+7:8k].
    assign w_word      = r_word | (DATA_WIDTH'(byte_data_i) << {r_byte_idx, 3'b000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_n          <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_word_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE, ERROR: if (start_i) begin
                    r_state      <= HDR0;
                    r_busy       <= 1'b1;
                    r_done       <= 1'b0;
                    r_error      <= 1'b0;
                    r_word_count <= '0;
                    r_byte_idx   <= '0;
                    r_word       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_csum       <= '0;
`endif
                end
                HDR0: if (w_fire) begin
                    r_n[7:0] <= byte_data_i;
                    r_state  <= HDR1;
                end
                HDR1: if (w_fire) begin
                    r_n <= w_n;
                    if (w_n == 16'd0 || w_n > MAX_N) begin
                        r_state <= ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                LOAD: if (w_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ byte_data_i;
`endif
                    if (r_byte_idx == LAST_IDX) begin
                        r_wr_en      <= 1'b1;
                        r_wr_data    <= w_word;
                        r_wr_addr    <= ADDR_WIDTH'(r_word_count);
                        r_word_count <= r_word_count + 16'd1;
                        r_byte_idx   <= '0;
                        r_word       <= '0;
                        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state <= CHK;
`else
                            // Final write, done and busy drop all land in the same cycle.
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end
                    end else begin
                        r_word     <= w_word;
                        r_byte_idx <= r_byte_idx + 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                // Memory is already written; a mismatch only marks its contents invalid.
                CHK: if (w_fire) begin
                    r_busy <= 1'b0;
                    if (byte_data_i == r_csum) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ERROR;
                        r_error <= 1'b1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ready and busy cover exactly the same states, so they share one register.
    assign byte_ready_o = r_busy;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign wr_en_o      = r_wr_en;
    assign wr_addr_o    = r_wr_addr;
    assign wr_data_o    = r_wr_data;
    assign word_count_o = r_word_count;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a byte-counting reference model
module tb_imem_loader;
    localparam int AW = 32, DW = 32, PL = 10, BPW = DW / 8;
    logic clk = 0, rst_n = 0, start_i = 0, byte_valid_i = 0;
    logic [7:0] byte_data_i = 0;
    logic byte_ready_o, wr_en_o, busy_o, done_o, error_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic [15:0] word_count_o;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROGRAM_LENGTH(PL)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .byte_valid_i(byte_valid_i),
        .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o), .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .word_count_o(word_count_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    bit m_busy = 0, m_done = 0, m_err = 0, exp_wr = 0;
    int m_cnt = 0, m_n = 0, m_wc = 0, exp_addr = 0, p;
    logic [DW-1:0] m_word = 0, exp_data = 0;
    logic [7:0] m_x = 0;
    logic [AW-1:0] log_a[$];
    logic [DW-1:0] log_d[$];
    logic [7:0] pl[$];

    // Model state computed at one falling edge describes the DUT after the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_wc = 0; exp_wr = 0;
        end
        chk("wr_en", wr_en_o, exp_wr);
        if (exp_wr) begin
            chk("wr_addr", wr_addr_o, exp_addr);
            chk("wr_data", wr_data_o, exp_data);
        end
        if (wr_en_o) begin
            log_a.push_back(wr_addr_o);
            log_d.push_back(wr_data_o);
        end
        chk("busy", busy_o, m_busy);
        chk("ready", byte_ready_o, m_busy);
        chk("done", done_o, m_done);
        chk("error", error_o, m_err);
        chk("word_count", word_count_o, m_wc);
        exp_wr = 0;
        if (rst_n) begin
            if (!m_busy && start_i) begin
                m_busy = 1; m_done = 0; m_err = 0; m_wc = 0; m_cnt = 0; m_word = 0; m_x = 0;
            end else if (m_busy && byte_valid_i) begin
                if (m_cnt == 0) m_n = byte_data_i;
                else if (m_cnt == 1) begin
                    m_n += byte_data_i * 256;
                    if (m_n == 0 || m_n > PL) begin m_busy = 0; m_err = 1; end
                end else begin
                    p = m_cnt - 2;
                    if (p < m_n * BPW) begin
                        m_word[8*(p%BPW) +: 8] = byte_data_i;
                        m_x ^= byte_data_i;
                        if (p % BPW == BPW - 1) begin
                            exp_wr = 1; exp_addr = p / BPW; exp_data = m_word; m_word = 0; m_wc++;
`ifndef IMEM_LOADER_CHECKSUM_EN
                            if (p == m_n * BPW - 1) begin m_busy = 0; m_done = 1; end
`endif
                        end
                    end else begin
                        m_busy = 0;
                        if (byte_data_i == m_x) m_done = 1; else m_err = 1;
                    end
                end
                m_cnt++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    function automatic int gp(input int g, input bit f);
        return f ? g : int'($urandom_range(0, g));
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        byte_valid_i = 0;
        repeat (gap) cyc();
        byte_valid_i = 1; byte_data_i = b; t = 0;
        while (!byte_ready_o && t < 100) begin cyc(); t++; end
        if (!byte_ready_o) chk("ready_timeout", byte_ready_o, 1'b1);
        cyc();
        byte_valid_i = 0;
    endtask

    task automatic fill(input int nb);
        pl.delete();
        repeat (nb) pl.push_back(8'($urandom));
    endtask

    task automatic run_load(input int n, input int g, input bit f, input int trail);
        logic [7:0] x;
        x = 0;
        log_a.delete(); log_d.delete();
        start_i = 1; byte_valid_i = 1; byte_data_i = n[7:0];
        cyc();
        start_i = 0; byte_valid_i = 0;
        send(n[7:0], gp(g, f));
        send(n[15:8], gp(g, f));
        if (n >= 1 && n <= PL) begin
            foreach (pl[i]) begin send(pl[i], gp(g, f)); x ^= pl[i]; end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send(trail < 0 ? x : trail[7:0], gp(g, f));
`endif
        end
        repeat (3) cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) cyc();
        chk("rst_wr_en", wr_en_o, 0); chk("rst_wr_addr", wr_addr_o, 0); chk("rst_wr_data", wr_data_o, 0);
        chk("rst_busy", busy_o, 0); chk("rst_ready", byte_ready_o, 0); chk("rst_wc", word_count_o, 0);
        rst_n = 1;
        byte_valid_i = 1; byte_data_i = 8'h55;
        repeat (3) cyc();
        byte_valid_i = 0;

        pl = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        run_load(2, 0, 1, -1);
        chk("demo_nwr", log_a.size(), 2);
        if (log_a.size() == 2) begin
            chk("demo_a0", log_a[0], 0); chk("demo_d0", log_d[0], 32'h00A00513);
            chk("demo_a1", log_a[1], 1); chk("demo_d1", log_d[1], 32'h00B00593);
        end
        chk("demo_done", done_o, 1); chk("demo_wc", word_count_o, 2);
        byte_valid_i = 1; byte_data_i = 8'hAA;
        repeat (3) cyc();
        byte_valid_i = 0;

        foreach (pl[i]) pl[i] = pl[i];
        run_load(11, 0, 1, -1);
        chk("hdr11_err", error_o, 1); chk("hdr11_nwr", log_a.size(), 0);
        run_load(0, 0, 1, -1);
        chk("hdr0_err", error_o, 1); chk("hdr0_nwr", log_a.size(), 0);
        run_load(257, 1, 0, -1);
        chk("hdr257_err", error_o, 1);

        fill(PL * BPW);
        run_load(PL, 1, 1, -1);
        chk("full_nwr", log_a.size(), PL);
        foreach (log_a[i]) chk("full_addr", log_a[i], i);
        chk("full_done", done_o, 1);

        start_i = 1; cyc(); start_i = 0;
        send(8'h02, 0); send(8'h00, 0);
        repeat (6) send(8'($urandom), 0);
        rst_n = 0; cyc();
        chk("mid_rst_busy", busy_o, 0); chk("mid_rst_wc", word_count_o, 0); chk("mid_rst_data", wr_data_o, 0);
        cyc(); rst_n = 1;
        repeat (3) cyc();
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(1, 0, 1, -1);
        chk("rst_nwr", log_a.size(), 1);
        if (log_a.size() == 1) begin
            chk("rst_a0", log_a[0], 0); chk("rst_d0", log_d[0], 32'hEFBEADDE);
        end

        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, PL);
            fill(n * BPW);
            run_load(n, 2, 0, -1);
            chk("rand_nwr", log_a.size(), n);
            chk("rand_done", done_o, 1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        pl = '{8'h13, 8'h05, 8'hA0, 8'h00};
        run_load(1, 0, 1, 8'hB6);
        chk("csum_ok_done", done_o, 1);
        run_load(1, 0, 1, 8'hB7);
        chk("csum_bad_err", error_o, 1); chk("csum_bad_nwr", log_a.size(), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
